// File: rtl/sr_reg_bank.sv
// Bank of independent set/reset bits. Each bit has its own set/reset
// inputs and a selectable rule for the case where both are asserted.
// The active clock edge is chosen at build time. A registered change
// flag, a conflict flag and a saturating conflict counter are also kept.
module sr_reg_bank #(
  parameter int                WIDTH         = 8,
  parameter int                CONFLICT_MODE = 1,
  parameter int                NEG_EDGE      = 1,
  parameter int                CNT_W         = 8,
  parameter logic [WIDTH-1:0]  RST_VAL       = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  s,
  input  logic [WIDTH-1:0]  r,
  input  logic              clr_cnt,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qn,
  output logic              changed,
  output logic              conflict,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // Unknown conflict modes fall back to hold.
  localparam int MODE = (CONFLICT_MODE >= 0 && CONFLICT_MODE <= 4) ? CONFLICT_MODE : 0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] last;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] last_nxt;
  logic             changed_nxt;
  logic             conflict_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  assign qn = ~q;

  // Next-state for every bit, the change/conflict flags and the counter.
  always_comb begin
    q_nxt    = q;
    last_nxt = last;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({s[i], r[i]})
          2'b01: begin
            q_nxt[i]    = 1'b0;
            last_nxt[i] = 1'b0;
          end
          2'b10: begin
            q_nxt[i]    = 1'b1;
            last_nxt[i] = 1'b1;
          end
          2'b11: begin
            case (MODE)
              1:       q_nxt[i] = 1'b1;
              2:       q_nxt[i] = 1'b0;
              3:       q_nxt[i] = ~q[i];
              4:       q_nxt[i] = last[i];
              default: q_nxt[i] = q[i];
            endcase
          end
          default: q_nxt[i] = q[i];
        endcase
      end
    end
    conflict_nxt = en & (|(s & r));
    changed_nxt  = (q_nxt != q);
    if (clr_cnt)
      cnt_nxt = '0;
    else if (conflict_nxt && (conflict_cnt != CNT_MAX))
      cnt_nxt = conflict_cnt + CNT_W'(1);
    else
      cnt_nxt = conflict_cnt;
  end

  generate
    if (NEG_EDGE != 0) begin : g_neg
      // State register on the falling edge; reset wins over everything.
      always_ff @(negedge clk) begin
        if (rst) begin
          q            <= RST_VAL;
          last         <= RST_VAL;
          changed      <= 1'b0;
          conflict     <= 1'b0;
          conflict_cnt <= '0;
        end else begin
          q            <= q_nxt;
          last         <= last_nxt;
          changed      <= changed_nxt;
          conflict     <= conflict_nxt;
          conflict_cnt <= cnt_nxt;
        end
      end
    end else begin : g_pos
      // State register on the rising edge; reset wins over everything.
      always_ff @(posedge clk) begin
        if (rst) begin
          q            <= RST_VAL;
          last         <= RST_VAL;
          changed      <= 1'b0;
          conflict     <= 1'b0;
          conflict_cnt <= '0;
        end else begin
          q            <= q_nxt;
          last         <= last_nxt;
          changed      <= changed_nxt;
          conflict     <= conflict_nxt;
          conflict_cnt <= cnt_nxt;
        end
      end
    end
  endgenerate

endmodule
